// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM: counting modes, count direction
// and the helper that locates one channel's duty field in the packed duty bus.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Usable in constant expressions, e.g. to slice the duty bus per channel.
  function automatic int unsigned chan_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: double-buffered duty/polarity and a registered comparator
// that is evaluated against the phase the counter moves to on this edge.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             swap,
  input  logic [WIDTH-1:0] phase_next,
  input  logic [WIDTH-1:0] high_time,
  input  logic             invert,
  output logic             out
);

  logic [WIDTH-1:0] ht_sh;
  logic [WIDTH-1:0] ht_next;
  logic             inv_sh;
  logic             inv_next;
  logic             out_next;

  // Using the post-swap shadows lets new settings govern phase 0 of a new period.
  always_comb begin
    ht_next  = swap ? high_time : ht_sh;
    inv_next = swap ? invert : inv_sh;
    out_next = inv_next;
    if (enable) begin
      out_next = (phase_next < ht_next) ^ inv_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ht_sh  <= '0;
      inv_sh <= 1'b0;
      out    <= 1'b0;
    end else begin
      ht_sh  <= ht_next;
      inv_sh <= inv_next;
      out    <= out_next;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with one shared period counter (edge or center aligned)
// and settings that are swapped in only at period boundaries.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      mode,
  input  logic [WIDTH-1:0]          wave_length,
  input  logic [CHANNELS*WIDTH-1:0] high_time,
  input  logic [CHANNELS-1:0]       invert,
  input  logic                      load,
  output logic                      load_done,
  output logic [CHANNELS-1:0]       out,
  output logic                      last_cycle
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] wl_sh;
  logic [WIDTH-1:0] wl_d;
  dir_t             dir_q;
  dir_t             dir_d;
  logic             mode_sh;
  logic             mode_d;
  logic             pending_q;
  logic             pending_d;
  logic             running_q;
  logic             at_end;
  logic             boundary;
  logic             swap;
  logic             last_d;

  // True when phase p is the last one of its period; wl<=1 in center mode
  // never reaches the down-count, so it wraps exactly like edge mode.
  function automatic logic final_phase(input logic [WIDTH-1:0] p, input dir_t d,
                                       input logic [WIDTH-1:0] wl, input logic md);
    if (md == MODE_EDGE || wl <= ONE) begin
      return p >= wl;
    end
    return (d == DIR_DOWN) && (p == ONE);
  endfunction

  // running_q low means the next enabled edge starts a fresh, full period at phase 0.
  always_comb begin
    at_end    = final_phase(count_q, dir_q, wl_sh, mode_sh);
    boundary  = !enable || !running_q || at_end;
    swap      = boundary && (pending_q || load);
    pending_d = swap ? 1'b0 : (pending_q | load);
    wl_d      = swap ? wave_length : wl_sh;
    mode_d    = swap ? mode : mode_sh;
    count_d   = '0;
    dir_d     = DIR_UP;
    if (enable && running_q && !at_end) begin
      if (mode_sh == MODE_CENTER && (dir_q == DIR_DOWN || count_q >= wl_sh)) begin
        count_d = count_q - ONE;
        dir_d   = DIR_DOWN;
      end else begin
        count_d = count_q + ONE;
        dir_d   = dir_q;
      end
    end
    last_d = enable && final_phase(count_d, dir_d, wl_d, mode_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      dir_q      <= DIR_UP;
      wl_sh      <= '0;
      mode_sh    <= MODE_EDGE;
      pending_q  <= 1'b0;
      running_q  <= 1'b0;
      load_done  <= 1'b0;
      last_cycle <= 1'b0;
    end else begin
      count_q    <= count_d;
      dir_q      <= dir_d;
      wl_sh      <= wl_d;
      mode_sh    <= mode_d;
      pending_q  <= pending_d;
      running_q  <= enable;
      load_done  <= swap;
      last_cycle <= last_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .swap      (swap),
      .phase_next(count_d),
      .high_time (high_time[chan_lsb(i, WIDTH) +: WIDTH]),
      .invert    (invert[i]),
      .out       (out[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: a period-position model checked every cycle,
// plus hand-derived waveform literals for each scenario.
module tb_pwm_multi;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic                      enable = 1'b0;
  logic                      mode = 1'b0;
  logic                      load = 1'b0;
  logic [WIDTH-1:0]          wave_length = '0;
  logic [CHANNELS*WIDTH-1:0] high_time = '0;
  logic [CHANNELS-1:0]       invert = '0;
  logic                      load_done;
  logic [CHANNELS-1:0]       out;
  logic                      last_cycle;

  int   total = 0;
  int   bad = 0;
  logic done = 1'b0;

  logic [CHANNELS-1:0] cap_out [32];
  logic                cap_last[32];
  logic                cap_ld  [32];

  pwm_multi #(
    .WIDTH   (WIDTH),
    .CHANNELS(CHANNELS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .wave_length(wave_length),
    .high_time  (high_time),
    .invert     (invert),
    .load       (load),
    .load_done  (load_done),
    .out        (out),
    .last_cycle (last_cycle)
  );

  always #5 clk = ~clk;

  // Model state: position t inside the current period rather than a counter.
  int                  m_t = 0;
  bit                  m_run = 1'b0;
  bit                  m_pend = 1'b0;
  int                  sh_wl = 0;
  bit                  sh_mode = 1'b0;
  int                  sh_ht[CHANNELS];
  logic [CHANNELS-1:0] sh_inv = '0;
  logic [CHANNELS-1:0] m_out = '0;
  logic                m_last = 1'b0;
  logic                m_ld = 1'b0;

  function automatic int period_of(input int wl, input bit md);
    return (md && wl != 0) ? 2 * wl : wl + 1;
  endfunction

  function automatic int phase_of(input int t, input int wl, input bit md);
    if (!md) return t;
    return (t <= wl) ? t : 2 * wl - t;
  endfunction

  function automatic logic [31:0] packHt(input int h0, input int h1, input int h2, input int h3);
    return {8'(h3), 8'(h2), 8'(h1), 8'(h0)};
  endfunction

  initial begin
    for (int c = 0; c < CHANNELS; c++) sh_ht[c] = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_t = 0; m_run = 1'b0; m_pend = 1'b0; sh_wl = 0; sh_mode = 1'b0; sh_inv = '0;
        for (int c = 0; c < CHANNELS; c++) sh_ht[c] = 0;
        m_out = '0; m_last = 1'b0; m_ld = 1'b0;
      end else begin
        bit period_end;
        bit boundary;
        bit swap;
        int ph;
        period_end = (m_t == period_of(sh_wl, sh_mode) - 1);
        boundary   = !enable || !m_run || period_end;
        swap       = boundary && (m_pend || load);
        m_ld       = swap;
        m_pend     = swap ? 1'b0 : (m_pend || load);
        if (swap) begin
          sh_wl = int'(wave_length); sh_mode = mode; sh_inv = invert;
          for (int c = 0; c < CHANNELS; c++) sh_ht[c] = int'(high_time[c*WIDTH +: WIDTH]);
        end
        if (!enable) begin
          m_run = 1'b0; m_t = 0;
          m_out = sh_inv; m_last = 1'b0;
        end else begin
          if (!m_run || period_end) m_t = 0;
          else m_t = m_t + 1;
          m_run  = 1'b1;
          ph     = phase_of(m_t, sh_wl, sh_mode);
          m_last = (m_t == period_of(sh_wl, sh_mode) - 1);
          for (int c = 0; c < CHANNELS; c++) m_out[c] = (ph < sh_ht[c]) ^ sh_inv[c];
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total = total + 1;
    if (actual !== expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic md, input int wl,
                               input logic [31:0] ht, input logic [CHANNELS-1:0] inv);
    enable      = en;
    mode        = md;
    wave_length = WIDTH'(wl);
    high_time   = ht;
    invert      = inv;
  endtask

  // Samples one cycle per negedge; load/enable changes land on the indexed sample.
  task automatic captureSeq(input int n, input int loadAt, input int offAt, input int onAt);
    for (int i = 0; i < n; i++) begin
      load = (i == loadAt);
      if (i == offAt) enable = 1'b0;
      if (i == onAt) enable = 1'b1;
      cap_out[i]  = out;
      cap_last[i] = last_cycle;
      cap_ld[i]   = load_done;
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  function automatic logic [31:0] seqOut(input int ch, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = cap_out[i][ch];
    return v;
  endfunction

  function automatic logic [31:0] seqLast(input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = cap_last[i];
    return v;
  endfunction

  function automatic logic [31:0] seqLd(input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = cap_ld[i];
    return v;
  endfunction

  initial begin
    @(negedge clk);
    while (!done) begin
      checkOutput("model_out", 32'(out), 32'(m_out));
      checkOutput("model_last", 32'(last_cycle), 32'(m_last));
      checkOutput("model_load_done", 32'(load_done), 32'(m_ld));
      @(negedge clk);
    end
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    checkOutput("reset_out", 32'(out), 32'h0);
    checkOutput("reset_last", 32'(last_cycle), 32'h0);
    checkOutput("reset_load_done", 32'(load_done), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] edge mode wl=4");
    applyStimulus(1'b1, 1'b0, 4, packHt(2, 0, 5, 200), 4'b0000);
    captureSeq(11, 0, -1, -1);
    checkOutput("edge_out0", seqOut(0, 11), 32'b00011000110);
    checkOutput("edge_out1", seqOut(1, 11), 32'b0);
    checkOutput("edge_out2", seqOut(2, 11), 32'b11111111110);
    checkOutput("edge_out3", seqOut(3, 11), 32'b11111111110);
    checkOutput("edge_last", seqLast(11), 32'b10000100000);
    checkOutput("edge_load_done", seqLd(11), 32'b00000000010);

    $display("[TB] mid-period reload");
    applyStimulus(1'b1, 1'b0, 4, packHt(3, 0, 5, 200), 4'b0000);
    captureSeq(10, 2, -1, -1);
    checkOutput("reload_out0", seqOut(0, 10), 32'b0011100011);
    checkOutput("reload_load_done", seqLd(10), 32'b0000100000);
    checkOutput("reload_last", seqLast(10), 32'b1000010000);

    $display("[TB] enable toggle");
    captureSeq(12, -1, 2, 5);
    checkOutput("enable_out0", seqOut(0, 12), 32'b100111000111);
    checkOutput("enable_out2", seqOut(2, 12), 32'b111111000111);
    checkOutput("enable_last", seqLast(12), 32'b010000000000);

    $display("[TB] invert");
    applyStimulus(1'b1, 1'b0, 4, packHt(2, 0, 5, 200), 4'b0001);
    captureSeq(13, 0, 10, -1);
    checkOutput("invert_out0", seqOut(0, 13), 32'b1100111000011);
    checkOutput("invert_out2", seqOut(2, 13), 32'b0011111111111);
    checkOutput("invert_load_done", seqLd(13), 32'b0000000010000);

    $display("[TB] center mode wl=4");
    applyStimulus(1'b1, 1'b1, 4, packHt(2, 0, 5, 200), 4'b0000);
    captureSeq(18, 0, -1, -1);
    checkOutput("center_out0", seqOut(0, 18), 32'b110000011100000111);
    checkOutput("center_out1", seqOut(1, 18), 32'b0);
    checkOutput("center_out3", seqOut(3, 18), 32'b111111111111111110);
    checkOutput("center_last", seqLast(18), 32'b010000000100000000);
    checkOutput("center_load_done", seqLd(18), 32'b000000000000000010);

    $display("[TB] center mode wl=0");
    applyStimulus(1'b1, 1'b1, 0, packHt(1, 0, 5, 200), 4'b0000);
    captureSeq(10, 0, -1, -1);
    checkOutput("wl0_out0", seqOut(0, 10), 32'b1111000001);
    checkOutput("wl0_last", seqLast(10), 32'b1111000000);
    checkOutput("wl0_load_done", seqLd(10), 32'b0010000000);

    $display("[TB] async reset");
    applyStimulus(1'b1, 1'b0, 4, packHt(2, 0, 5, 200), 4'b0000);
    captureSeq(3, 0, -1, -1);
    high_time = packHt(3, 0, 5, 200);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    #1 checkOutput("pre_reset_out", 32'(out), 32'b1100);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_reset_out", 32'(out), 32'h0);
    checkOutput("async_reset_last", 32'(last_cycle), 32'h0);
    checkOutput("async_reset_load_done", 32'(load_done), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    captureSeq(4, -1, -1, -1);
    for (int c = 0; c < CHANNELS; c++) checkOutput("post_reset_out", seqOut(c, 4), 32'b0);
    checkOutput("post_reset_load_done", seqLd(4), 32'b0);
    applyStimulus(1'b1, 1'b0, 4, packHt(2, 0, 5, 200), 4'b0000);
    captureSeq(3, 0, -1, -1);
    checkOutput("reload_after_reset_out", 32'(cap_out[1]), 32'b1101);
    checkOutput("reload_after_reset_load_done", seqLd(3), 32'b010);

    done = 1'b1;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Multi-channel successor to the single-channel PWM.
- CHANNELS outputs share one period counter. Each channel has its own duty value and output polarity.
- Supports edge-aligned and center-aligned counting.
- Duty, period, mode and polarity settings are double-buffered. New settings take effect only at a period boundary, so no runt pulses occur.
- Drives motor/LED/servo pins from a register block clocked by clk.

Parameters:
- WIDTH, 16, bit width of the counter, period and duty values.
- CHANNELS, 4, number of independent PWM outputs (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- enable  input  1  1 = run; 0 = hold counter at phase 0 and drive idle levels.
- mode  input  1  0 = edge-aligned, 1 = center-aligned (taken on load).
- wave_length  input  WIDTH  period control (taken on load).
- high_time  input  CHANNELS*WIDTH  duty per channel; channel i is bits [i*WIDTH +: WIDTH] (taken on load).
- invert  input  CHANNELS  per-channel output polarity (taken on load).
- load  input  1  one-cycle request to transfer inputs into the shadow registers.
- load_done  output  1  one-cycle pulse when the shadow registers are updated.
- out  output  CHANNELS  PWM outputs, registered.
- last_cycle  output  1  high during the final phase of every period, registered.

Behaviour:
- Reset (async, no clock needed):
  - counter=0, direction=up, pending=0.
  - shadow wl/ht/mode/invert = 0.
  - out=0, last_cycle=0, load_done=0.
- Phase:
  - Phase p is the registered counter value.
  - out and last_cycle are registered on the same edge as the counter, so they reflect the current phase with zero lag.
- out[i] = (p < ht_sh[i]) XOR inv_sh[i]. Comparisons are unsigned, WIDTH bits.
- Edge mode:
  - p sequence: 0,1,...,wl_sh, then 0.
  - Period = wl_sh+1 cycles.
  - last_cycle=1 when p==wl_sh.
  - wl_sh=0 gives period 1 with last_cycle constantly 1.
- Center mode:
  - p counts up 0..wl_sh, then down wl_sh-1..1, then 0.
  - Period = 2*wl_sh cycles. The high pulse is centered on p=0.
  - last_cycle=1 at p==1 on the down-count.
  - wl_sh=0 behaves exactly as edge mode with wl_sh=0.
  - A 1-bit direction register is used; no counter widening is needed.
- Duty limits:
  - ht_sh[i]=0 gives constant inactive level.
  - ht_sh[i] > max phase (wl_sh) gives constant active level (100%), with no glitch at the wrap.
- Load:
  - load sets pending.
  - At the boundary edge (counter returning to 0, or any edge while enable=0) with pending or load high:
    - the shadows capture the current inputs;
    - pending clears;
    - load_done pulses in the following cycle, i.e. phase 0 of the new period.
  - The new values already govern phase 0 of the new period.
  - load coincident with a boundary edge applies at that boundary.
  - Repeated load before the boundary is allowed; the last input values at the boundary win.
- enable=0:
  - counter=0, direction=up, last_cycle=0.
  - out[i]=inv_sh[i].
  - On re-enable, counting starts at phase 0 on the next edge, with a full first period.
- rst asserted mid-period:
  - Immediate return to the reset state.
  - Any pending load is discarded.
- No combinational path from inputs to outputs.

Decomposition:
- Package pwm_pkg holds:
  - MODE_EDGE=1'b0, MODE_CENTER=1'b1;
  - a localparam function for the channel slice index.
- Sub-module pwm_channel, instantiated CHANNELS times by generate. It contains:
  - the ht/inv shadow registers;
  - the comparator and output flop;
  - inputs: phase, swap strobe, enable.
- The top level holds the counter, direction, wl/mode shadows, pending/load_done and last_cycle.

Test Plan:
- Edge mode, WIDTH=8, wl=4, ht0=2, ht1=0, ht2=5, ht3=200, load pulsed:
  - out0 = 1,1,0,0,0 repeating;
  - out1 constant 0;
  - out2 and out3 constant 1;
  - last_cycle high on every 5th cycle, at p=4.
- Mid-period reload: wl=4, ht0=2 running; load at p=2 with ht0=3:
  - the current period is unchanged;
  - the next period gives 1,1,1,0,0;
  - load_done pulses exactly at that p=0.
- Center mode, wl=4, ht0=2:
  - p = 0,1,2,3,4,3,2,1;
  - out0 = 1,1,0,0,0,0,0,1;
  - last_cycle high at the final p=1;
  - period 8 cycles.
- Invert: invert=4'b0001, ht0=2, wl=4:
  - out0 = 0,0,1,1,1;
  - with enable=0, out0=1 and out1..3=0.
- Async reset: assert rst at p=3 between clock edges:
  - out, last_cycle and load_done are 0 before the next clk edge;
  - after release, a new load is needed and outputs stay 0 until it is applied.
- Enable toggle: drop enable at p=2 for 3 cycles, then restore:
  - the counter holds at 0;
  - the first period after re-enable is full length, 5 cycles, for wl=4.
